// File: rtl/fpu_pkg.sv
// Shared FPU sequencer types: float container, divide-sequencer states and
// the latency counter width used by every multi-cycle FPU sequencer.
package fpu_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } fdiv_state_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake of the divide sequencer.
// Both sides follow valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; valid and its payload hold until then.
interface fdiv_seq_if;
  import fpu_pkg::*;

  logic     in_valid;
  logic     in_ready;
  float32_t x1;
  float32_t x2;
  logic     out_valid;
  logic     out_ready;
  float32_t y;
  logic     ovf;
  logic     udf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf, udf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf, udf
  );

endinterface

// File: rtl/lat_counter.sv
// Down-counter for fixed-latency unit waits: load, decrement, zero flag.
module lat_counter
  import fpu_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Divide sequencer: y = x1 * finv(x2) using time-shared external finv and
// fmul units, with overflow/underflow flags accumulated over both steps.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int INV_LAT = 1,
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  fdiv_seq_if.slave   bus,
  output logic        finv_en,
  output float32_t    finv_x,
  input  float32_t    finv_y,
  input  logic        finv_ovf,
  input  logic        finv_udf,
  output logic        fmul_en,
  output float32_t    fmul_x1,
  output float32_t    fmul_x2,
  input  float32_t    fmul_y,
  input  logic        fmul_ovf,
  input  logic        fmul_udf,
  output fdiv_state_t dbg_state
);

  if (INV_LAT < 1 || INV_LAT > 15) begin : g_bad_inv_lat
    $error("fdiv_seq: INV_LAT must be in 1..15");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("fdiv_seq: MUL_LAT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] INV_LOAD = LAT_W'(INV_LAT - 1);
  localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);

  fdiv_state_t      state;
  fdiv_state_t      state_nxt;
  logic             in_ready;
  logic             out_valid;
  logic             cnt_load;
  logic             cnt_dec;
  logic [LAT_W-1:0] cnt_load_val;
  logic [LAT_W-1:0] cnt;
  logic             cnt_zero;
  logic             accept;
  float32_t         r_x1;
  float32_t         y_q;
  logic             ovf_q;
  logic             udf_q;

  lat_counter #(.W(LAT_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign accept    = bus.in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = INV;
      INV:  if (cnt_zero)      state_nxt = MUL;
      MUL:  if (cnt_zero)      state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Counter is reloaded for the next wait on the same edge a wait ends.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    finv_en      = 1'b0;
    fmul_en      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = INV_LOAD;
    case (state)
      IDLE: begin
        in_ready     = 1'b1;
        cnt_load     = bus.in_valid;
        cnt_load_val = INV_LOAD;
      end
      INV: begin
        finv_en      = 1'b1;
        cnt_load     = cnt_zero;
        cnt_dec      = !cnt_zero;
        cnt_load_val = MUL_LOAD;
      end
      MUL: begin
        fmul_en = 1'b1;
        cnt_dec = !cnt_zero;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Unit operand registers change only on the edge their enable rises, so
  // they hold their last value while the sequencer does not own the unit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x1    <= '0;
      finv_x  <= '0;
      fmul_x1 <= '0;
      fmul_x2 <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        r_x1   <= bus.x1;
        finv_x <= bus.x2;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end
      if (state == INV && cnt_zero) begin
        fmul_x1 <= r_x1;
        fmul_x2 <= finv_y;
        ovf_q   <= ovf_q | finv_ovf;
        udf_q   <= udf_q | finv_udf;
      end
      if (state == MUL && cnt_zero) begin
        y_q   <= fmul_y;
        ovf_q <= ovf_q | fmul_ovf;
        udf_q <= udf_q | fmul_udf;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;

endmodule
